key_debounce_multi: RTL and testbench

- Parametrised multi-channel push-button conditioner; successor to the single-key debouncer.
- Per channel it performs:
  - 2-FF synchronisation of the raw key.
  - Integrate-and-confirm debouncing.
  - Polarity normalisation.
  - Press, release and long-press event detection.
- Sits between board key pins and UI/control logic; all outputs are synchronous to clk.

---
 rtl/key_debounce_multi.sv | 209 ++++++++++++++++++++
 tb/tb_key_debounce_multi.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// key_debounce_multi
//   Multi-channel push-button conditioner. Each channel synchronises its raw
//   pin (2 FFs), debounces it with a restartable confirm counter, normalises
//   polarity (1 = pressed) and produces press / release / long-press pulses.
//
//   Optional feature macro: KEY_REPEAT_EN
//     defined   : after key_long the channel auto-repeats every RPT_CNT cycles
//     undefined : no repeat logic, key_repeat tied to 0
//
//   Ports
//     clk          system clock
//     rst_n        asynchronous active-low reset
//     ikey         [NUM_KEYS] raw asynchronous key pins
//     key_state    [NUM_KEYS] debounced level, 1 = pressed
//     key_press    [NUM_KEYS] 1-cycle pulse on key_state rise
//     key_release  [NUM_KEYS] 1-cycle pulse on key_state fall
//     key_long     [NUM_KEYS] 1-cycle pulse LONG_CNT cycles after key_press
//     key_repeat   [NUM_KEYS] 1-cycle auto-repeat pulse
//     any_event    registered OR of all pulses, aligned with them

module key_debounce_chan #(
    parameter int DB_CNT     = 10,
    parameter int LONG_CNT   = 1000,
    parameter int RPT_CNT    = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ikey,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat,
    output logic evt_nxt
);
    localparam int DBW = $clog2(DB_CNT + 1);
    localparam int HW  = $clog2(LONG_CNT + 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CNT - 1);
    localparam logic [HW-1:0]  LONG_LAST = HW'(LONG_CNT - 1);
    localparam logic [HW-1:0]  LONG_MAX  = HW'(LONG_CNT);

    if (DB_CNT < 1 || LONG_CNT <= DB_CNT || RPT_CNT < 1) begin : g_bad_cfg
        $error("key_debounce_chan: need DB_CNT>=1, LONG_CNT>DB_CNT, RPT_CNT>=1");
    end

    typedef enum logic [1:0] {RELEASED = 2'd0, PRESSED = 2'd1, REPEATING = 2'd2} state_t;

    state_t           state, state_nxt;
    logic             s1, s2, n;
    logic [DBW-1:0]   db_cnt;
    logic [HW-1:0]    hold_cnt;
    logic             toggle, long_hit, rpt_hit;
    logic             press_d, release_d, long_d, repeat_d;

    // Sync FFs idle at the released pin level so reset exit looks quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= ACTIVE_LOW;
            s2 <= ACTIVE_LOW;
        end else begin
            s1 <= ikey;
            s2 <= s1;
        end
    end
    assign n = s2 ^ ACTIVE_LOW;

    // Confirm counter: any sample equal to the current state restarts it.
    assign toggle = (n != key_state) && (db_cnt == DB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        db_cnt <= '0;
        else if (n == key_state || toggle) db_cnt <= '0;
        else                               db_cnt <= db_cnt + DBW'(1);
    end

    // Hold counter saturates at LONG_CNT, so long_hit fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            hold_cnt <= '0;
        else if (state == RELEASED || toggle)  hold_cnt <= '0;
        else if (hold_cnt != LONG_MAX)         hold_cnt <= hold_cnt + HW'(1);
    end
    assign long_hit = !toggle && (hold_cnt == LONG_LAST);

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(RPT_CNT + 1);
    logic [RW-1:0] rpt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        rpt_cnt <= '0;
        else if (state != REPEATING || toggle || rpt_hit)  rpt_cnt <= '0;
        else                                               rpt_cnt <= rpt_cnt + RW'(1);
    end
    assign rpt_hit = (state == REPEATING) && !toggle && (rpt_cnt == RW'(RPT_CNT - 1));
`else
    assign rpt_hit = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RELEASED;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            RELEASED: if (toggle) state_nxt = PRESSED;
            PRESSED: begin
                if (toggle) state_nxt = RELEASED;
`ifdef KEY_REPEAT_EN
                else if (long_hit) state_nxt = REPEATING;
`endif
            end
            default:  if (toggle) state_nxt = RELEASED;
        endcase
    end

    // FSM: outputs (pulse values are registered below)
    always_comb begin
        key_state = (state != RELEASED);
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state)
            RELEASED: press_d = toggle;
            PRESSED: begin
                release_d = toggle;
                long_d    = long_hit;
            end
            default: begin
                release_d = toggle;
                repeat_d  = rpt_hit;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            key_press   <= press_d;
            key_release <= release_d;
            key_long    <= long_d;
            key_repeat  <= repeat_d;
        end
    end

    assign evt_nxt = press_d | release_d | long_d | repeat_d;
endmodule

module key_debounce_multi #(
    parameter int NUM_KEYS      = 4,
    parameter int CLK_FREQ_HZ   = 65_000_000,
    parameter int DEBOUNCE_US   = 20_000,
    parameter int LONG_PRESS_MS = 1000,
    parameter int REPEAT_MS     = 200,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] ikey,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                any_event
);
    localparam int DB_CNT   = CLK_FREQ_HZ / 1_000_000 * DEBOUNCE_US;
    localparam int LONG_CNT = CLK_FREQ_HZ / 1000 * LONG_PRESS_MS;
    localparam int RPT_CNT  = CLK_FREQ_HZ / 1000 * REPEAT_MS;

    if (NUM_KEYS < 1 || NUM_KEYS > 32) begin : g_bad_num
        $error("key_debounce_multi: NUM_KEYS must be 1..32");
    end

    logic [NUM_KEYS-1:0] evt_nxt;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_chan #(
            .DB_CNT    (DB_CNT),
            .LONG_CNT  (LONG_CNT),
            .RPT_CNT   (RPT_CNT),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .ikey       (ikey[i]),
            .key_state  (key_state[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i]),
            .key_repeat (key_repeat[i]),
            .evt_nxt    (evt_nxt[i])
        );
    end

    // Registered from the same next-values as the pulses, so it lines up with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) any_event <= 1'b0;
        else        any_event <= |evt_nxt;
    end
endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed scenarios plus random key activity,
// every cycle compared against a reference model built from the event rules
// (last DB_CNT synchronised samples all differ -> toggle; long/repeat by
// elapsed time since the press).
module tb_key_debounce_multi;
    localparam int NK = 4;
    localparam int DB = 10;
    localparam int LC = 1000;
    localparam int RC = 1000;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] ikey = '1;
    logic [NK-1:0] key_state, key_press, key_release, key_long, key_repeat;
    logic          any_event;

    key_debounce_multi #(
        .NUM_KEYS(NK), .CLK_FREQ_HZ(1_000_000), .DEBOUNCE_US(10),
        .LONG_PRESS_MS(1), .REPEAT_MS(1), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ikey(ikey),
        .key_state(key_state), .key_press(key_press), .key_release(key_release),
        .key_long(key_long), .key_repeat(key_repeat), .any_event(any_event)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model
    logic [NK-1:0] m_state, e_press, e_rel, e_long, e_rep;
    logic          e_any;
    int            cyc = 0;
    int            t_press[NK];
    logic [NK-1:0] pipe[$];
    logic [NK-1:0] hist[$];

    // Observation counters
    int            o_press[NK], o_long[NK], o_rep[NK], t_po[NK], t_lo[NK];
    logic [NK-1:0] last_pv = '0;

    function automatic void mdl_reset();
        m_state = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0; e_any = 1'b0;
        pipe.delete(); hist.delete();
        pipe.push_back('0);
        pipe.push_back('0);
    endfunction

    function automatic void mdl_edge();
        logic [NK-1:0] seen, tog;
        bit all_diff;
        int d;
        cyc++;
        pipe.push_back(~ikey);
        seen = pipe.pop_front();
        hist.push_back(seen);
        if (hist.size() > DB) void'(hist.pop_front());
        for (int i = 0; i < NK; i++) begin
            all_diff = (hist.size() == DB);
            for (int j = 0; j < hist.size(); j++)
                if (hist[j][i] == m_state[i]) all_diff = 1'b0;
            tog[i] = all_diff;
        end
        e_press = tog & ~m_state;
        e_rel   = tog & m_state;
        for (int i = 0; i < NK; i++) begin
            d = cyc - t_press[i];
            e_long[i] = m_state[i] && !tog[i] && d == LC;
            e_rep[i]  = REP_EN && m_state[i] && !tog[i] && d > LC && ((d - LC) % RC) == 0;
            if (e_press[i]) t_press[i] = cyc;
        end
        m_state = m_state ^ tog;
        e_any = |{e_press, e_rel, e_long, e_rep};
    endfunction

    task automatic step();
        @(posedge clk);
        mdl_edge();
        @(negedge clk);
        chk($sformatf("outs@%0d", cyc),
            {any_event, key_repeat, key_long, key_release, key_press, key_state},
            {e_any, e_rep, e_long, e_rel, e_press, m_state});
        for (int i = 0; i < NK; i++) begin
            if (key_press[i]) begin o_press[i]++; t_po[i] = cyc; end
            if (key_long[i])  begin o_long[i]++;  t_lo[i] = cyc; end
            if (key_repeat[i]) o_rep[i]++;
        end
        if (key_press != '0) last_pv = key_press;
    endtask

    task automatic edge_lat(input int ch, input logic v, output int lat);
        lat = -1;
        ikey[ch] = v;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (lat < 0 && (key_press[ch] || key_release[ch])) lat = k;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_entry", {any_event, key_repeat, key_long, key_release, key_press, key_state}, '0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold", {any_event, key_repeat, key_long, key_release, key_press, key_state}, '0);
        end
        mdl_reset();
        rst_n = 1'b1;
    endtask

    int lat, p0, l0, r0, len;

    initial begin
        for (int i = 0; i < NK; i++) begin
            o_press[i] = 0; o_long[i] = 0; o_rep[i] = 0; t_po[i] = 0; t_lo[i] = 0; t_press[i] = 0;
        end
        mdl_reset();
        repeat (4) begin
            @(negedge clk);
            chk("reset", {any_event, key_repeat, key_long, key_release, key_press, key_state}, '0);
        end
        rst_n = 1'b1;
        repeat (20) step();

        // clean press / release latency
        edge_lat(0, 1'b0, lat); chk("press_lat", lat, 12);
        edge_lat(0, 1'b1, lat); chk("release_lat", lat, 12);

        // chatter on key 1, then settle low
        p0 = o_press[1];
        for (int k = 0; k < 40; k++) begin
            ikey[1] = ~ikey[1];
            repeat (5) step();
        end
        chk("chatter_press", o_press[1] - p0, 0);
        edge_lat(1, 1'b0, lat); chk("chatter_lat", lat, 12);
        ikey[1] = 1'b1;
        repeat (30) step();

        // long press on key 2, then a short hold
        l0 = o_long[2];
        ikey[2] = 1'b0;
        repeat (1100) step();
        chk("long_once", o_long[2] - l0, 1);
        chk("long_dist", t_lo[2] - t_po[2], LC);
        ikey[2] = 1'b1;
        repeat (30) step();
        ikey[2] = 1'b0;
        repeat (900) step();
        ikey[2] = 1'b1;
        repeat (30) step();
        chk("long_short", o_long[2] - l0, 1);

        // simultaneous press on keys 0 and 3
        ikey = 4'b0110;
        repeat (30) step();
        chk("dual_press", last_pv, 4'b1001);
        ikey = '1;
        repeat (30) step();

        // long hold on key 0: repeat behaviour depends on the build
        l0 = o_long[0]; r0 = o_rep[0];
        ikey[0] = 1'b0;
        repeat (3512) step();
        ikey[0] = 1'b1;
        repeat (40) step();
        chk("hold_long", o_long[0] - l0, 1);
        chk("hold_repeat", o_rep[0] - r0, REP_EN ? 2 : 0);

        // random key activity
        for (int s = 0; s < 40; s++) begin
            ikey = NK'($urandom);
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(900, 1300) : $urandom_range(2, 40);
            repeat (len) step();
        end
        ikey = '1;
        repeat (30) step();

        // reset in the middle of a count and while a key is held
        ikey = 4'b1101;
        repeat (20) step();
        ikey[0] = 1'b0;
        repeat (6) step();
        do_reset();
        p0 = o_press[0];
        repeat (30) step();
        chk("post_rst_press", o_press[0] - p0, 1);
        ikey = '1;
        repeat (30) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
